// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, start/busy/done handshake.
// Optional build macro BIN2BCD_BLANK_EN replaces leading zero digits above digit 0 with 4'hF.
module bin2bcd_seq #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if ((2 ** WIDTH) > (10 ** DIGITS)) begin : g_param_check
        $error("bin2bcd_seq: 2**WIDTH-1 exceeds the range of DIGITS BCD digits");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [SW-1:0]     r_scratch;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_bcd;

    state_t            w_state_nxt;
    logic [WIDTH-1:0]  w_shreg_nxt;
    logic [SW-1:0]     w_scratch_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [SW-1:0]     w_bcd_nxt;

    logic [SW-1:0]     w_shift_scratch;
    logic [WIDTH-1:0]  w_shift_shreg;
    logic [SW-1:0]     w_load;
    logic [3:0]        w_digit;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Correct every digit, then shift {scratch,shreg} left by one. The MSB of the
    // top corrected digit is always 0 under the parameter constraint and is dropped.
    always_comb begin
        w_shift_scratch    = '0;
        w_digit            = '0;
        w_shift_scratch[0] = r_shreg[WIDTH-1];
        for (int d = 0; d < DIGITS; d++) begin
            w_digit = add3(r_scratch[4*d +: 4]);
            w_shift_scratch[4*d+1 +: 3] = w_digit[2:0];
            if (d < DIGITS - 1) begin
                w_shift_scratch[4*d+4] = w_digit[3];
            end
        end
        w_shift_shreg = {r_shreg[WIDTH-2:0], 1'b0};
    end

`ifdef BIN2BCD_BLANK_EN
    logic w_lead;
    always_comb begin
        w_load = w_shift_scratch;
        w_lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (w_lead && (w_shift_scratch[4*d +: 4] == 4'd0)) begin
                w_load[4*d +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_load = w_shift_scratch;
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        case (r_state)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start exactly like IDLE, giving back-to-back throughput.
                if (start) begin
                    w_shreg_nxt   = bin;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SHIFT;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_shreg_nxt   = w_shift_shreg;
                w_scratch_nxt = w_shift_scratch;
                w_cnt_nxt     = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_bcd_nxt   = w_load;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bcd     <= w_bcd_nxt;
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake/latency vectors plus a /10 %10 reference model.
// Define BIN2BCD_BLANK_EN for both files to exercise the leading-zero blanking build.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [12:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int nb    = 0;
    int lat   = 0;
    int ov_cnt  = 0;
    int dbl_cnt = 0;
    logic done_q = 1'b0;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [15:0] EXP_0   = 16'hFFF0;
    localparam logic [15:0] EXP_510 = 16'hF510;
    localparam logic [15:0] EXP_42  = 16'hFF42;
    localparam logic [15:0] EXP_7   = 16'hFFF7;
`else
    localparam logic [15:0] EXP_0   = 16'h0000;
    localparam logic [15:0] EXP_510 = 16'h0510;
    localparam logic [15:0] EXP_42  = 16'h0042;
    localparam logic [15:0] EXP_7   = 16'h0007;
`endif
    localparam logic [15:0] EXP_8191 = 16'h8191;

    bin2bcd_seq #(.WIDTH(13), .DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // protocol monitor: done must be a single-cycle pulse, never together with busy
    always @(negedge clk) begin
        if (busy && done) ov_cnt++;
        if (done && done_q) dbl_cnt++;
        done_q = done;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int v);
        logic [15:0] r;
        bit lead;
        r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`ifdef BIN2BCD_BLANK_EN
        lead = 1'b1;
        for (int d = 3; d >= 1; d--) begin
            if (lead && r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    // Called at a negedge: drives start for the next edge (E0) and returns at the negedge after E0.
    task automatic accept(input logic [12:0] v, input bit hold);
        start = 1'b1;
        bin   = v;
        t0    = cyc + 1;
        @(negedge clk);
        nb = busy ? 1 : 0;
        if (!hold) start = 1'b0;
    endtask

    // Waits (bounded) for done; lat is the edge index since E0 at which done was seen.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
        lat = cyc - t0;
    endtask

    initial begin
        int t_first;
        int n_done;
        int v;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_bcd",  32'(bcd),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // zero input: latency and busy window
        accept(13'd0, 1'b0);
        wait_done("zero");
        check_eq("zero_latency", 32'(lat), 32'd13);
        check_eq("zero_busy_cycles", 32'(nb), 32'd13);
        check_eq("zero_bcd", 32'(bcd), 32'(EXP_0));

        // full scale and adder-style sum
        accept(13'd8191, 1'b0);
        wait_done("max");
        check_eq("max_bcd", 32'(bcd), 32'(EXP_8191));
        accept(13'd510, 1'b0);
        wait_done("s510");
        check_eq("s510_latency", 32'(lat), 32'd13);
        check_eq("s510_bcd", 32'(bcd), 32'(EXP_510));

        // start held high with a different bin while busy is ignored
        accept(13'd42, 1'b1);
        bin = 13'd99;
        repeat (10) @(negedge clk);
        check_eq("hold_busy", 32'(busy), 32'd1);
        check_eq("hold_bcd_prev", 32'(bcd), 32'(EXP_510));
        start = 1'b0;
        wait_done("hold");
        check_eq("hold_latency", 32'(lat), 32'd13);
        check_eq("hold_bcd", 32'(bcd), 32'(EXP_42));

        // back-to-back accept in the DONE cycle
        t_first = cyc;
        accept(13'd7, 1'b0);
        wait_done("b2b");
        check_eq("b2b_period", 32'(cyc - t_first), 32'd14);
        check_eq("b2b_bcd", 32'(bcd), 32'(EXP_7));

        // reset on E5 abandons the conversion
        accept(13'd1234, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        check_eq("rst_mid_bcd",  32'(bcd),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("rst_mid_no_done", 32'(n_done), 32'd0);
        check_eq("rst_mid_bcd_after", 32'(bcd), 32'h0);

        // reference model on random operands
        for (int i = 0; i < 12; i++) begin
            v = $urandom_range(0, 8191);
            accept(13'(v), 1'b0);
            wait_done("rand");
            check_eq($sformatf("rand_bcd_%0d", v), 32'(bcd), 32'(model(v)));
        end

        check_eq("busy_and_done", 32'(ov_cnt), 32'd0);
        check_eq("done_one_cycle", 32'(dbl_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
